// File: rtl/table_mp.sv
// -----------------------------------------------------------------------------
// table_mp - multi-port register table with a background clear sweep.
//
// Purpose:
//   TABLE_SIZE x DATA_WIDTH storage with WR_PORTS independent write ports and
//   RD_PORTS independent pipelined read ports (RD_LATENCY of 1 or 2). A clr
//   request starts a sweep that writes CLR_VALUE to one entry per cycle.
//   Port traffic is ignored while the sweep runs.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   wr_en     per-port write enable            [WR_PORTS]
//   index_wr  per-port write index, slice j     [WR_PORTS*IW]
//   data_wr   per-port write data, slice j      [WR_PORTS*DATA_WIDTH]
//   rd_en     per-port read request             [RD_PORTS]
//   index_rd  per-port read index, slice k      [RD_PORTS*IW]
//   data_rd   per-port read data, slice k       [RD_PORTS*DATA_WIDTH]
//   rd_valid  one-cycle pulse per accepted read [RD_PORTS]
//   clr       start the clear sweep
//   busy      high while the clear sweep runs
//
// Build option:
//   TABLE_BYPASS_EN  when defined, a read and a write to the same index in the
//                    same cycle return the new (highest-port) write data.
//                    Otherwise the pre-write contents are returned.
//
// Clear FSM:
//   state | meaning
//   IDLE  | normal port access
//   CLEAR | pointer sweeps 0..TABLE_SIZE-1 writing CLR_VALUE, busy=1
// -----------------------------------------------------------------------------
module table_mp #(
    parameter int                    TABLE_SIZE = 32,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    WR_PORTS   = 2,
    parameter int                    RD_PORTS   = 2,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0,
    localparam int                   IW         = $clog2(TABLE_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WR_PORTS-1:0]            wr_en,
    input  logic [WR_PORTS*IW-1:0]         index_wr,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] data_wr,
    input  logic [RD_PORTS-1:0]            rd_en,
    input  logic [RD_PORTS*IW-1:0]         index_rd,
    output logic [RD_PORTS*DATA_WIDTH-1:0] data_rd,
    output logic [RD_PORTS-1:0]            rd_valid,
    input  logic                           clr,
    output logic                           busy
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;

    logic [DATA_WIDTH-1:0] mem_q [TABLE_SIZE];
    logic [DATA_WIDTH-1:0] rd_word [RD_PORTS];

    logic [RD_LATENCY-1:0][RD_PORTS-1:0]                 vld_q;
    logic [RD_LATENCY-1:0][RD_PORTS-1:0][DATA_WIDTH-1:0] dat_q;

    assign busy = (state_q == CLEAR);

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                ptr_d = '0;
                if (clr) state_d = CLEAR;
            end
            CLEAR: begin
                if (ptr_q == IW'(TABLE_SIZE - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- storage ----------------
    // Ports are visited in ascending order so the highest port's non-blocking
    // assignment lands last and wins on a shared index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TABLE_SIZE; i++) mem_q[i] <= '0;
        end else if (busy) begin
            mem_q[ptr_q] <= CLR_VALUE;
        end else begin
            for (int j = 0; j < WR_PORTS; j++) begin
                if (wr_en[j] && (int'(index_wr[(j+1)*IW-1 -: IW]) < TABLE_SIZE))
                    mem_q[index_wr[(j+1)*IW-1 -: IW]] <= data_wr[(j+1)*DATA_WIDTH-1 -: DATA_WIDTH];
            end
        end
    end

    // ---------------- read word select ----------------
    // Out-of-range indices read as zero rather than aliasing into the table.
    always_comb begin
        for (int k = 0; k < RD_PORTS; k++) begin
            rd_word[k] = '0;
            if (int'(index_rd[(k+1)*IW-1 -: IW]) < TABLE_SIZE)
                rd_word[k] = mem_q[index_rd[(k+1)*IW-1 -: IW]];
`ifdef TABLE_BYPASS_EN
            for (int j = 0; j < WR_PORTS; j++) begin
                if (wr_en[j] && !busy
                    && (index_wr[(j+1)*IW-1 -: IW] == index_rd[(k+1)*IW-1 -: IW])
                    && (int'(index_rd[(k+1)*IW-1 -: IW]) < TABLE_SIZE))
                    rd_word[k] = data_wr[(j+1)*DATA_WIDTH-1 -: DATA_WIDTH];
            end
`endif
        end
    end

    // ---------------- read pipeline ----------------
    // Data registers only load alongside a valid, so each output holds its
    // last delivered word between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            for (int k = 0; k < RD_PORTS; k++) begin
                vld_q[0][k] <= rd_en[k] && !busy;
                if (rd_en[k] && !busy) dat_q[0][k] <= rd_word[k];
                for (int s = 1; s < RD_LATENCY; s++) begin
                    vld_q[s][k] <= vld_q[s-1][k];
                    if (vld_q[s-1][k]) dat_q[s][k] <= dat_q[s-1][k];
                end
            end
        end
    end

    assign data_rd  = dat_q[RD_LATENCY-1];
    assign rd_valid = vld_q[RD_LATENCY-1];

endmodule

// File: doc/table_mp.md
TABLE_MP -- requirements
Module: table_mp

Interface
REQ-001 SHALL provide parameter TABLE_SIZE, default 32, number of entries (>=2, need not be a power of two).
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, bits per entry.
REQ-003 SHALL provide parameter WR_PORTS, default 2, number of independent write ports.
REQ-004 SHALL provide parameter RD_PORTS, default 2, number of independent read ports.
REQ-005 SHALL provide parameter RD_LATENCY, default 1, read pipeline depth in cycles, legal values 1 or 2.
REQ-006 SHALL provide parameter CLR_VALUE, default 0, DATA_WIDTH-bit value written by the clear sweep.
REQ-007 SHALL define IW = $clog2(TABLE_SIZE) as the per-port index width.
REQ-008 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port wr_en, input, WR_PORTS, per-port write enable.
REQ-011 SHALL have port index_wr, input, WR_PORTS*IW, port j index in slice [(j+1)*IW-1 -: IW].
REQ-012 SHALL have port data_wr, input, WR_PORTS*DATA_WIDTH, port j data in slice j.
REQ-013 SHALL have port rd_en, input, RD_PORTS, per-port read request.
REQ-014 SHALL have port index_rd, input, RD_PORTS*IW, port k read index in slice k.
REQ-015 SHALL have port data_rd, output, RD_PORTS*DATA_WIDTH, port k read data in slice k.
REQ-016 SHALL have port rd_valid, output, RD_PORTS, one-cycle pulse qualifying data_rd slice k.
REQ-017 SHALL have port clr, input, 1, request to sweep all entries to CLR_VALUE.
REQ-018 SHALL have port busy, output, 1, high while the clear sweep runs.

Function
REQ-019 Write: at each edge with wr_en[j]=1 and busy=0, entry index_wr[j] SHALL take data_wr[j]; all ports in the same cycle.
REQ-020 Same-index multi-port write in one cycle: highest port number SHALL win; others discarded.
REQ-021 Index >= TABLE_SIZE: write SHALL be dropped; read SHALL return all zeros with rd_valid still pulsed.
REQ-022 Read: rd_en[k]=1 sampled at edge N with busy=0 SHALL give data_rd[k] and rd_valid[k]=1 after edge N+RD_LATENCY-1, i.e. visible in the cycle following edge N for RD_LATENCY=1.
REQ-023 rd_valid[k] SHALL be high for exactly one cycle per accepted request; back-to-back requests SHALL yield back-to-back valids (full throughput).
REQ-024 data_rd[k] SHALL hold its last value when no valid is presented.
REQ-025 Read-during-write to the same index in the same cycle SHALL return the pre-write data (see REQ-033 for the override).
REQ-026 Clear FSM states IDLE and CLEAR; IDLE->CLEAR on edge with clr=1; busy=1 from the next cycle.
REQ-027 In CLEAR, a pointer SHALL step 0..TABLE_SIZE-1, writing CLR_VALUE to one entry per cycle; busy SHALL stay high exactly TABLE_SIZE cycles, then the FSM returns to IDLE.
REQ-028 clr during CLEAR SHALL be ignored; wr_en and rd_en sampled while busy=1 SHALL be ignored (no write, no rd_valid).
REQ-029 clr and wr_en in the same IDLE cycle: the write SHALL occur and then be overwritten by the sweep.
REQ-030 Reads accepted before busy rose SHALL complete normally.

Reset
REQ-031 rst=1 at an edge SHALL set all entries to zero, data_rd=0, rd_valid=0, busy=0, FSM to IDLE, pointer to 0, and flush the read pipeline.
REQ-032 rst during CLEAR SHALL abort the sweep; rst SHALL override every simultaneous wr_en, rd_en and clr.

Configuration
REQ-033 With TABLE_BYPASS_EN defined, a same-cycle read and write to one index SHALL return the new (winning-port) data; without it, REQ-025 holds and no forwarding logic SHALL be built.

Verification
REQ-034 Write idx 3=0xA5 (port0), idx 7=0x3C (port1) in one cycle; read both next cycle -> rd_valid=2'b11, data 0xA5 and 0x3C after RD_LATENCY.
REQ-035 Both ports write idx 5 (0x11 port0, 0x22 port1) -> later read of idx 5 returns 0x22.
REQ-036 Idx 9=0x55, then same cycle write idx 9=0x66 and read idx 9 -> 0x55 without macro, 0x66 with TABLE_BYPASS_EN.
REQ-037 Fill table, pulse clr -> busy high exactly 32 cycles; reads issued during busy give no rd_valid; afterwards every index reads CLR_VALUE.
REQ-038 Assert rst 10 cycles into a clear -> busy=0 next cycle, all entries read 0, rd_valid=0 during reset.
REQ-039 TABLE_SIZE=20: write idx 25=0xFF -> dropped; read idx 25 -> 0 with rd_valid=1.
